// File: rtl/fpu_wb_buffer.sv
// -----------------------------------------------------------------------------
// fpu_wb_buffer
// Writeback buffer that sits directly after the FP ALU EX register. ALU
// results (value, destination register, overflow, target register file) are
// queued in a DEPTH-entry FIFO. Whenever the shared register-file write port is
// granted, the oldest entry is moved into a registered write stage (out_*).
// The buffer also keeps a sticky overflow flag and forwards pending FP results
// to decode.
//
// Ports
//   CLK, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  ALU result handshake (in_ready comes from registered count)
//   in_result/in_overflow/in_rd/in_to_int   ALU result fields
//   flush              synchronous drop of every buffered entry
//   wb_grant           write port granted this cycle
//   out_we/out_is_int/out_rd/out_data       registered register-file write
//   fflags_clr/fflags_of                    sticky overflow clear / flag
//   fwd_addr/fwd_hit/fwd_data               combinational FP forwarding lookup
//   count              number of occupied entries
// -----------------------------------------------------------------------------
module fpu_wb_buffer #(
   parameter int FLEN  = 32,
   parameter int DEPTH = 2,
   parameter int RAW   = 5
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FLEN-1:0]          in_result,
   input  logic                     in_overflow,
   input  logic [RAW-1:0]           in_rd,
   input  logic                     in_to_int,
   input  logic                     flush,
   input  logic                     wb_grant,
   output logic                     out_we,
   output logic                     out_is_int,
   output logic [RAW-1:0]           out_rd,
   output logic [FLEN-1:0]          out_data,
   input  logic                     fflags_clr,
   output logic                     fflags_of,
   input  logic [RAW-1:0]           fwd_addr,
   output logic                     fwd_hit,
   output logic [FLEN-1:0]          fwd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [FLEN-1:0] result;
      logic            ovf;
      logic [RAW-1:0]  rd;
      logic            to_int;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            out_we_q, out_we_d;
   logic            out_is_int_q, out_is_int_d;
   logic [RAW-1:0]  out_rd_q, out_rd_d;
   logic [FLEN-1:0] out_data_q, out_data_d;
   logic            of_q, of_d;

   entry_t          in_entry_s;
   entry_t          head_s;
   logic            push_s;
   logic            pop_s;
   logic            of_set_s;

   // Handshake and head-of-queue decode; ready depends only on registered count.
   always_comb begin
      in_entry_s = '{result: in_result, ovf: in_overflow, rd: in_rd, to_int: in_to_int};
      head_s     = mem_q[rd_ptr_q];
      in_ready   = (count_q < CW'(DEPTH));
      push_s     = in_valid & in_ready & ~flush;
      pop_s      = (count_q != {CW{1'b0}}) & wb_grant & ~flush;
      of_set_s   = pop_s & head_s.ovf;
   end

   // Next-state logic for FIFO storage, pointers, write stage and sticky flag.
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      out_we_d     = 1'b0;
      out_is_int_d = out_is_int_q;
      out_rd_d     = out_rd_q;
      out_data_d   = out_data_q;
      of_d         = of_q;

      if (flush) begin
         // Flush wins over any same-cycle push or pop.
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_d[wr_ptr_q] = in_entry_s;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop_s) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            out_is_int_d = head_s.to_int;
            out_rd_d     = head_s.rd;
            out_data_d   = head_s.result;
            // Integer x0 is hard-wired zero: the entry retires without a write.
            out_we_d     = ~(head_s.to_int & (head_s.rd == {RAW{1'b0}}));
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      // Set beats clear so an overflow retiring in the clear cycle is not lost.
      if (of_set_s) begin
         of_d = 1'b1;
      end else if (fflags_clr) begin
         of_d = 1'b0;
      end else begin
         of_d = of_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= {PW{1'b0}};
         rd_ptr_q     <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         out_we_q     <= 1'b0;
         out_is_int_q <= 1'b0;
         out_rd_q     <= {RAW{1'b0}};
         out_data_q   <= {FLEN{1'b0}};
         of_q         <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_we_q     <= out_we_d;
         out_is_int_q <= out_is_int_d;
         out_rd_q     <= out_rd_d;
         out_data_q   <= out_data_d;
         of_q         <= of_d;
      end
   end

   // Forwarding: the write stage has lowest priority, then buffered entries are
   // scanned oldest to youngest so the youngest match overrides earlier ones.
   always_comb begin
      logic [PW-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = {FLEN{1'b0}};
      idx      = {PW{1'b0}};
      if (out_we_q && !out_is_int_q && (out_rd_q == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = out_data_q;
      end else begin
         fwd_hit  = 1'b0;
         fwd_data = {FLEN{1'b0}};
      end
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PW'(k);
         if ((CW'(k) < count_q) && !mem_q[idx].to_int && (mem_q[idx].rd == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_q[idx].result;
         end else begin
            fwd_hit  = fwd_hit;
            fwd_data = fwd_data;
         end
      end
   end

   // Output mapping of the registered state.
   always_comb begin
      out_we     = out_we_q;
      out_is_int = out_is_int_q;
      out_rd     = out_rd_q;
      out_data   = out_data_q;
      fflags_of  = of_q;
      count      = count_q;
   end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Testbench for fpu_wb_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_fpu_wb_buffer;

   localparam int FLEN  = 32;
   localparam int DEPTH = 2;
   localparam int RAW   = 5;

   logic            CLK = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, in_overflow, in_to_int;
   logic [FLEN-1:0] in_result;
   logic [RAW-1:0]  in_rd;
   logic            flush, wb_grant;
   logic            out_we, out_is_int;
   logic [RAW-1:0]  out_rd;
   logic [FLEN-1:0] out_data;
   logic            fflags_clr, fflags_of;
   logic [RAW-1:0]  fwd_addr;
   logic            fwd_hit;
   logic [FLEN-1:0] fwd_data;
   logic [$clog2(DEPTH):0] count;

   fpu_wb_buffer #(.FLEN(FLEN), .DEPTH(DEPTH), .RAW(RAW)) dut (
      .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_overflow(in_overflow), .in_rd(in_rd),
      .in_to_int(in_to_int), .flush(flush), .wb_grant(wb_grant),
      .out_we(out_we), .out_is_int(out_is_int), .out_rd(out_rd),
      .out_data(out_data), .fflags_clr(fflags_clr), .fflags_of(fflags_of),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [FLEN-1:0] v;
      logic [RAW-1:0]  rd;
      logic            ti;
      logic            ov;
   } ent_t;

   ent_t            q[$];
   logic            m_we, m_int, m_of;
   logic [RAW-1:0]  m_rd;
   logic [FLEN-1:0] m_data;
   int              n_tests = 0;
   int              n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_we = 1'b0; m_int = 1'b0; m_of = 1'b0; m_rd = '0; m_data = '0;
   endtask

   // Apply the inputs present at a clock edge to the model.
   task automatic model_step();
      bit   acc, pop, set;
      ent_t h;
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() > 0) && wb_grant;
      set = 1'b0;
      if (flush) begin
         q.delete();
         m_we = 1'b0;
      end else begin
         if (pop) begin
            h = q.pop_front();
            m_we = !(h.ti && h.rd == 0);
            m_int = h.ti; m_rd = h.rd; m_data = h.v;
            set = h.ov;
         end else begin
            m_we = 1'b0;
         end
         if (acc) q.push_back('{v: in_result, rd: in_rd, ti: in_to_int, ov: in_overflow});
      end
      if (set) m_of = 1'b1;
      else if (fflags_clr) m_of = 1'b0;
   endtask

   task automatic check_all();
      bit              hit;
      logic [FLEN-1:0] d;
      hit = 1'b0; d = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!hit && !q[i].ti && q[i].rd == fwd_addr) begin
            hit = 1'b1; d = q[i].v;
         end
      end
      if (!hit && m_we && !m_int && m_rd == fwd_addr) begin
         hit = 1'b1; d = m_data;
      end
      chk("in_ready", in_ready, (q.size() < DEPTH));
      chk("count", count, q.size());
      chk("out_we", out_we, m_we);
      if (m_we) begin
         chk("out_is_int", out_is_int, m_int);
         chk("out_rd", out_rd, m_rd);
         chk("out_data", out_data, m_data);
      end
      chk("fflags_of", fflags_of, m_of);
      chk("fwd_hit", fwd_hit, hit);
      chk("fwd_data", fwd_data, d);
   endtask

   task automatic cycle();
      #1 check_all();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_result = '0; in_overflow = 1'b0; in_rd = '0; in_to_int = 1'b0;
      flush = 1'b0; wb_grant = 1'b0; fflags_clr = 1'b0; fwd_addr = '0;
   endtask

   task automatic push(input logic [FLEN-1:0] v, input logic [RAW-1:0] rd,
                       input logic ti, input logic ov);
      in_valid = 1'b1; in_result = v; in_rd = rd; in_to_int = ti; in_overflow = ov;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_count", count, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_is_int", out_is_int, 0);
      check_all();
      #10 rst_n = 1'b1;
      @(posedge CLK); #1;

      // Single push with grant: visible one cycle after the pop edge.
      push(32'h3F800000, 5'd3, 1'b0, 1'b0); wb_grant = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("t1_we", out_we, 1'b1);
      chk("t1_rd", out_rd, 5'd3);
      chk("t1_data", out_data, 32'h3F800000);
      chk("t1_count", count, 0);
      cycle();

      // Fill with grant off: third push refused.
      wb_grant = 1'b0;
      push(32'h11111111, 5'd1, 1'b0, 1'b0); cycle();
      push(32'h22222222, 5'd2, 1'b0, 1'b0); cycle();
      push(32'h33333333, 5'd4, 1'b0, 1'b0); cycle();
      chk("full_ready", in_ready, 1'b0);
      chk("full_count", count, 2);
      in_valid = 1'b0; wb_grant = 1'b1;
      cycle(); chk("drain0", out_data, 32'h11111111);
      cycle(); chk("drain1", out_data, 32'h22222222);
      cycle(); chk("drain_done_we", out_we, 1'b0);

      // Youngest-wins forwarding.
      wb_grant = 1'b0;
      push(32'hAAAA0000, 5'd5, 1'b0, 1'b0); cycle();
      push(32'hBBBB0000, 5'd5, 1'b0, 1'b0); cycle();
      in_valid = 1'b0; fwd_addr = 5'd5; #1;
      chk("fwd5_hit", fwd_hit, 1'b1);
      chk("fwd5_data", fwd_data, 32'hBBBB0000);
      fwd_addr = 5'd6; #1;
      chk("fwd6_hit", fwd_hit, 1'b0);
      flush = 1'b1; cycle(); flush = 1'b0;

      // Overflow set beats same-cycle clear; later lone clear drops it.
      push(32'h7F800000, 5'd7, 1'b0, 1'b1); cycle();
      in_valid = 1'b0; wb_grant = 1'b1; fflags_clr = 1'b1; cycle();
      chk("of_set", fflags_of, 1'b1);
      wb_grant = 1'b0; cycle();
      chk("of_clr", fflags_of, 1'b0);
      fflags_clr = 1'b0;

      // Integer x0 retires without a write.
      push(32'h00000001, 5'd0, 1'b1, 1'b0); wb_grant = 1'b1; cycle();
      in_valid = 1'b0; cycle();
      chk("x0_we", out_we, 1'b0);
      chk("x0_count", count, 0);

      // Flush beats same-cycle push and pop.
      wb_grant = 1'b0;
      push(32'h44444444, 5'd8, 1'b0, 1'b0); cycle();
      push(32'h55555555, 5'd9, 1'b0, 1'b0); cycle();
      push(32'h66666666, 5'd10, 1'b0, 1'b0); wb_grant = 1'b1; flush = 1'b1; cycle();
      chk("flush_count", count, 0);
      chk("flush_we", out_we, 1'b0);
      flush = 1'b0;

      // Async reset mid-drain clears outputs immediately.
      wb_grant = 1'b0;
      push(32'h77777777, 5'd11, 1'b0, 1'b1); cycle();
      push(32'h88888888, 5'd12, 1'b0, 1'b0); cycle();
      in_valid = 1'b0; wb_grant = 1'b1; cycle();
      #2 rst_n = 1'b0; model_reset(); #1;
      chk("mrst_we", out_we, 1'b0);
      chk("mrst_data", out_data, 0);
      chk("mrst_rd", out_rd, 0);
      chk("mrst_of", fflags_of, 1'b0);
      chk("mrst_count", count, 0);
      idle();
      @(negedge CLK); rst_n = 1'b1;
      @(posedge CLK); #1;

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         in_valid    = ($urandom_range(99) < 60);
         in_result   = $urandom;
         in_rd       = RAW'($urandom_range(7));
         in_to_int   = ($urandom_range(3) == 0);
         in_overflow = ($urandom_range(4) == 0);
         wb_grant    = ($urandom_range(1) == 1);
         flush       = ($urandom_range(19) == 0);
         fflags_clr  = ($urandom_range(9) == 0);
         fwd_addr    = RAW'($urandom_range(7));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
